clk_phase_meter: RTL
====================

Name: clk_phase_meter

Overview:
- Measures the clocks produced by the clock-wizard stage by sampling them as data in the 100 MHz domain. The measured clocks are the 33 MHz reference and its phase-shifted copy.
- Per reference period it reports three values in sys_clk cycles: period, high time, and the rising-edge delay of the shifted clock.
- Results are averaged over 2^AVG_LOG2 periods and presented with a one-cycle valid strobe, for ILA/debug readout or a downstream checker.
- At top level, sys_clk is driven by clk_100m and locked by the wizard's locked output.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per sampled clock input (>=2).
- CNT_W, 16, width of the cycle counter and result outputs.
- AVG_LOG2, 3, log2 of the number of periods averaged per result.
- TIMEOUT, 1000, cycles without a reference rise before error; must be < 2^CNT_W-1.

Ports:
- sys_clk  in  1  measurement clock (100 MHz).
- sys_rst_n  in  1  async active-low reset.
- locked  in  1  clock-wizard lock; measurement only while high.
- meas_en  in  1  enable continuous measurement.
- clk_ref_in  in  1  reference clock, sampled as data.
- clk_dut_in  in  1  phase-shifted clock, sampled as data.
- period_cnt  out  CNT_W  averaged reference period, in cycles.
- high_cnt  out  CNT_W  averaged reference high time, in cycles.
- phase_cnt  out  CNT_W  averaged ref-rise to dut-rise delay, in cycles.
- meas_valid  out  1  one-cycle pulse when result outputs update.
- meas_busy  out  1  high in ARM/MEASURE.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- One clock; reset is asynchronous and active-low: sys_clk, sys_rst_n.
- Reset values: all outputs 0, FSM in IDLE, accumulators 0.
- Synchronization: both inputs pass through SYNC_STAGES flops plus one extra flop for edge detection.
  - rise = last sync stage 1 and the extra flop 0.
  - Input-to-rise-pulse latency is identical for both inputs, so relative phase is preserved.
- Cycle counter t:
  - Loads 1 on a ref rise and increments every cycle otherwise.
  - Saturates at 2^CNT_W-1.
- Per-period samples, taken within the window between two consecutive ref rises:
  - period = number of cycles from one rise to the next (the value of t in the cycle of the next rise, before reload).
  - high = number of cycles in the window with the synced ref level high.
  - phase = cycles from the ref rise to the first dut rise in the window; 0 if both rise in the same cycle.
  - If no dut rise occurs in the window, phase = period.
  - Later dut rises in the same window are ignored.
- Accumulators are CNT_W+AVG_LOG2 wide, one each for period, high and phase.
- FSM states:
  - IDLE: accumulators and window count cleared. Go to ARM when meas_en && locked.
  - ARM: wait for the first ref rise, then go to MEASURE (t=1). If t reaches TIMEOUT, go to ERROR.
  - MEASURE: each ref rise closes a window and adds its samples to the accumulators.
    - After 2^AVG_LOG2 windows, outputs <= accumulator >> AVG_LOG2 (truncating) and the accumulators clear.
    - meas_valid pulses in the cycle after that closing rise.
    - The same rise opens the next window, so measurement is continuous with no gap.
    - If t reaches TIMEOUT, go to ERROR.
  - ERROR: timeout_err=1, meas_busy=0. Go to IDLE (clearing timeout_err) when meas_en=0.
- meas_en=0 or locked=0 in ARM/MEASURE: go to IDLE next cycle.
  - The partial window is discarded; no meas_valid.
  - Result outputs hold their last values.
- Simultaneous events:
  - Ref rise and dut rise in the same cycle: phase=0 for the new window.
  - Closing rise and meas_en falling in the same cycle: the abort wins; no update.
- meas_valid is never asserted in consecutive cycles.
- Outputs are registered.

Test Plan:
- Reset: assert sys_rst_n=0 mid-MEASURE -> all outputs 0 immediately; FSM in IDLE; no meas_valid after release until 8 fresh windows complete.
- Nominal (AVG_LOG2=3): ref period 30, high 15, dut delayed 7 cycles; meas_en=locked=1 -> meas_valid after the arming rise plus 8 periods with period_cnt=30, high_cnt=15, phase_cnt=7; pulses repeat every 240 cycles.
- Averaging truncation: ref periods alternate 30/31, high 15, dut delay 5 -> period_cnt=30 (244/8), high_cnt=15, phase_cnt=5.
- Phase edge cases: dut coincident with ref -> phase_cnt=0; dut held low, period 30 -> phase_cnt=30.
- Timeout: ref stops low after arming -> timeout_err=1 exactly when t reaches TIMEOUT=1000; meas_busy=0, no meas_valid. Dropping meas_en -> timeout_err=0, state IDLE.
- Lock loss: locked=0 at window 5 -> no meas_valid, outputs keep previous results. When locked=1 again -> re-arm and next result after 8 full windows.

Source files
------------

// File: rtl/clk_phase_meter.sv
// clk_phase_meter: samples the clock-wizard reference clock and its
// phase-shifted copy as data in the sys_clk domain. For each reference period
// it measures the period, the high time and the ref-rise to dut-rise delay,
// all in sys_clk cycles. It averages these over 2^AVG_LOG2 periods and
// publishes each result with a one-cycle meas_valid strobe.
module clk_phase_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 3,
    parameter int TIMEOUT     = 1000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             locked,
    input  logic             meas_en,
    input  logic             clk_ref_in,
    input  logic             clk_dut_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             meas_valid,
    output logic             meas_busy,
    output logic             timeout_err
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam logic [CNT_W-1:0]  T_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  T_MAX    = '1;
    localparam logic [CNT_W-1:0]  T_TO_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [AVG_LOG2:0] WIN_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2:0] WIN_LAST = (AVG_LOG2 + 1)'((2 ** AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_ERROR
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] ref_sync, dut_sync;
    logic                   ref_d, dut_d;
    logic                   ref_lvl, ref_rise, dut_rise;

    logic [CNT_W-1:0]  t_cnt, high_run, phase_run;
    logic              dut_seen;
    logic [CNT_W-1:0]  phase_sample;
    logic [ACC_W-1:0]  acc_period, acc_high, acc_phase;
    logic [ACC_W-1:0]  sum_period, sum_high, sum_phase;
    logic [AVG_LOG2:0] win_cnt;

    logic active, close_win, publish;

    assign ref_lvl  = ref_sync[SYNC_STAGES-1];
    assign ref_rise = ref_lvl & ~ref_d;
    assign dut_rise = dut_sync[SYNC_STAGES-1] & ~dut_d;
    assign active   = meas_en & locked;

    // A window with no dut rise reports its full length as the phase.
    assign phase_sample = dut_seen ? phase_run : t_cnt;
    assign sum_period   = acc_period + ACC_W'(t_cnt);
    assign sum_high     = acc_high + ACC_W'(high_run);
    assign sum_phase    = acc_phase + ACC_W'(phase_sample);

    // Both inputs go through identical chains so their relative phase is kept.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ref_sync <= '0;
            dut_sync <= '0;
            ref_d    <= 1'b0;
            dut_d    <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], clk_ref_in};
            dut_sync <= {dut_sync[SYNC_STAGES-2:0], clk_dut_in};
            ref_d    <= ref_sync[SYNC_STAGES-1];
            dut_d    <= dut_sync[SYNC_STAGES-1];
        end
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus window-close / publish decisions; aborts beat a closing rise.
    always_comb begin
        state_next = state;
        close_win  = 1'b0;
        publish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active) state_next = ST_ARM;
            end
            ST_ARM: begin
                if (!active)               state_next = ST_IDLE;
                else if (ref_rise)         state_next = ST_MEASURE;
                else if (t_cnt == T_TO_M1) state_next = ST_ERROR;
            end
            ST_MEASURE: begin
                if (!active) begin
                    state_next = ST_IDLE;
                end else if (ref_rise) begin
                    close_win = 1'b1;
                    publish   = (win_cnt == WIN_LAST);
                end else if (t_cnt == T_TO_M1) begin
                    state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (!meas_en) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-window trackers: cycle counter, high-time count and first dut rise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t_cnt     <= '0;
            high_run  <= '0;
            phase_run <= '0;
            dut_seen  <= 1'b0;
        end else if (state == ST_IDLE) begin
            t_cnt     <= '0;
            high_run  <= '0;
            phase_run <= '0;
            dut_seen  <= 1'b0;
        end else if (ref_rise) begin
            t_cnt     <= T_ONE;
            high_run  <= T_ONE;
            phase_run <= '0;
            dut_seen  <= dut_rise;
        end else begin
            if (t_cnt != T_MAX) t_cnt <= t_cnt + T_ONE;
            if (ref_lvl && high_run != T_MAX) high_run <= high_run + T_ONE;
            if (dut_rise && !dut_seen) begin
                dut_seen  <= 1'b1;
                phase_run <= t_cnt;
            end
        end
    end

    // Accumulate closed windows and publish the truncated average every 2^AVG_LOG2.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_period <= '0;
            acc_high   <= '0;
            acc_phase  <= '0;
            win_cnt    <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            phase_cnt  <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state == ST_IDLE) begin
                acc_period <= '0;
                acc_high   <= '0;
                acc_phase  <= '0;
                win_cnt    <= '0;
            end else if (close_win) begin
                if (publish) begin
                    period_cnt <= CNT_W'(sum_period >> AVG_LOG2);
                    high_cnt   <= CNT_W'(sum_high >> AVG_LOG2);
                    phase_cnt  <= CNT_W'(sum_phase >> AVG_LOG2);
                    meas_valid <= 1'b1;
                    acc_period <= '0;
                    acc_high   <= '0;
                    acc_phase  <= '0;
                    win_cnt    <= '0;
                end else begin
                    acc_period <= sum_period;
                    acc_high   <= sum_high;
                    acc_phase  <= sum_phase;
                    win_cnt    <= win_cnt + WIN_ONE;
                end
            end
        end
    end

    // Registered status flags follow the state being entered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meas_busy   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            meas_busy   <= (state_next == ST_ARM) || (state_next == ST_MEASURE);
            timeout_err <= (state_next == ST_ERROR);
        end
    end

endmodule
